// File: rtl/core_reg_dispatch.sv
// core_reg_dispatch: forwards one upstream register request to the target block selected by
// the address tag. Define CORE_REG_DISPATCH_ERR_CNT_EN to add err_count/last_err_tag outputs.
module core_reg_dispatch #(
  parameter int ADDR_WIDTH     = 22,
  parameter int SUB_ADDR_WIDTH = 16,
  parameter int NUM_TARGETS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              up_reg_req,
  output logic                              up_reg_ack,
  input  logic                              up_reg_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]             up_reg_addr,
  input  logic [DATA_WIDTH-1:0]             up_reg_wr_data,
  output logic [DATA_WIDTH-1:0]             up_reg_rd_data,
  output logic [NUM_TARGETS-1:0]            down_reg_req,
  output logic                              down_reg_rd_wr_L,
  output logic [SUB_ADDR_WIDTH-1:0]         down_reg_addr,
  output logic [DATA_WIDTH-1:0]             down_reg_wr_data,
  input  logic [NUM_TARGETS-1:0]            down_reg_ack,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] down_reg_rd_data
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
  ,
  output logic [15:0]                       err_count,
  output logic [7:0]                        last_err_tag
`endif
);

  localparam int TAG_W = ADDR_WIDTH - SUB_ADDR_WIDTH;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, FWD, RESP, WAIT_DROP} state_t;

  state_t                 state_r;
  logic [15:0]            cnt_r;
  logic                   dropped_r;
  logic [TAG_W-1:0]       tag_s;
  logic [NUM_TARGETS-1:0] sel_s;
  logic                   mapped_s;
  logic                   ack_hit_s;
  logic                   timeout_s;
  logic                   drop_s;
  logic [DATA_WIDTH-1:0]  ack_data_s;

  assign tag_s     = up_reg_addr[ADDR_WIDTH-1:SUB_ADDR_WIDTH];
  assign mapped_s  = |sel_s;
  assign ack_hit_s = |(down_reg_ack & down_reg_req);
  assign timeout_s = (cnt_r == TIMEOUT_LAST);
  assign drop_s    = dropped_r | ~up_reg_req;

  // Tag decode to a one-hot select; tags at or above NUM_TARGETS decode to all zeros.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      sel_s[k] = (tag_s == TAG_W'(k));
    end
  end

  // Read-data mux keyed by the live one-hot request, so only the selected slice can reach upstream.
  always_comb begin
    ack_data_s = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      ack_data_s = ack_data_s |
                   ({DATA_WIDTH{down_reg_req[k]}} & down_reg_rd_data[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Dispatch FSM with all upstream/downstream outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      cnt_r            <= 16'd0;
      dropped_r        <= 1'b0;
      up_reg_ack       <= 1'b0;
      up_reg_rd_data   <= '0;
      down_reg_req     <= '0;
      down_reg_rd_wr_L <= 1'b0;
      down_reg_addr    <= '0;
      down_reg_wr_data <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          up_reg_ack <= 1'b0;
          if (up_reg_req) begin
            down_reg_rd_wr_L <= up_reg_rd_wr_L;
            down_reg_addr    <= up_reg_addr[SUB_ADDR_WIDTH-1:0];
            down_reg_wr_data <= up_reg_wr_data;
            cnt_r            <= 16'd0;
            dropped_r        <= 1'b0;
            if (mapped_s) begin
              down_reg_req <= sel_s;
              state_r      <= FWD;
            end else begin
              up_reg_rd_data <= ERR_DATA;
              up_reg_ack     <= 1'b1;
              state_r        <= RESP;
            end
          end
        end
        FWD: begin
          cnt_r <= cnt_r + 16'd1;
          if (!up_reg_req) begin
            dropped_r <= 1'b1;
          end
          // An abandoned request still finishes downstream but never acks upstream.
          if (ack_hit_s || timeout_s) begin
            down_reg_req <= '0;
            if (drop_s) begin
              state_r <= IDLE;
            end else begin
              up_reg_rd_data <= ack_hit_s ? ack_data_s : ERR_DATA;
              up_reg_ack     <= 1'b1;
              state_r        <= RESP;
            end
          end
        end
        RESP: begin
          up_reg_ack <= 1'b0;
          state_r    <= WAIT_DROP;
        end
        WAIT_DROP: begin
          up_reg_ack <= 1'b0;
          if (!up_reg_req) begin
            state_r <= IDLE;
          end
        end
        default: begin
          up_reg_ack   <= 1'b0;
          down_reg_req <= '0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
  logic [TAG_W-1:0] tag_r;
  logic             err_unmapped_s;
  logic             err_timeout_s;

  assign err_unmapped_s = (state_r == IDLE) && up_reg_req && !mapped_s;
  assign err_timeout_s  = (state_r == FWD) && !ack_hit_s && timeout_s && !drop_s;

  // Saturating error statistics for unmapped tags and timeouts that reach the response phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_r        <= '0;
      err_count    <= 16'd0;
      last_err_tag <= 8'd0;
    end else begin
      if (state_r == IDLE && up_reg_req) begin
        tag_r <= tag_s;
      end
      if (err_unmapped_s || err_timeout_s) begin
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
        last_err_tag <= err_unmapped_s ? 8'(tag_s) : 8'(tag_r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_reg_dispatch.sv
// Directed, table-driven bench for core_reg_dispatch (4 targets, TIMEOUT=8).
module tb_core_reg_dispatch;
  localparam int NT = 4;
  localparam int DW = 32;
  localparam int AW = 22;
  localparam int SW = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              up_reg_req;
  logic              up_reg_ack;
  logic              up_reg_rd_wr_L;
  logic [AW-1:0]     up_reg_addr;
  logic [DW-1:0]     up_reg_wr_data;
  logic [DW-1:0]     up_reg_rd_data;
  logic [NT-1:0]     down_reg_req;
  logic              down_reg_rd_wr_L;
  logic [SW-1:0]     down_reg_addr;
  logic [DW-1:0]     down_reg_wr_data;
  logic [NT-1:0]     down_reg_ack;
  logic [NT*DW-1:0]  down_reg_rd_data;
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
  logic [15:0]       err_count;
  logic [7:0]        last_err_tag;
`endif

  int checks = 0;
  int failures = 0;

  core_reg_dispatch #(
    .ADDR_WIDTH(AW), .SUB_ADDR_WIDTH(SW), .NUM_TARGETS(NT), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .up_reg_req(up_reg_req), .up_reg_ack(up_reg_ack), .up_reg_rd_wr_L(up_reg_rd_wr_L),
    .up_reg_addr(up_reg_addr), .up_reg_wr_data(up_reg_wr_data), .up_reg_rd_data(up_reg_rd_data),
    .down_reg_req(down_reg_req), .down_reg_rd_wr_L(down_reg_rd_wr_L),
    .down_reg_addr(down_reg_addr), .down_reg_wr_data(down_reg_wr_data),
    .down_reg_ack(down_reg_ack), .down_reg_rd_data(down_reg_rd_data)
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
    , .err_count(err_count), .last_err_tag(last_err_tag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;   // cycles after down_reg_req rises before the target acks
    logic [DW-1:0] tdata;
    logic          chk;
    logic [DW-1:0] exp_data;
    int            exp_lat;   // up_reg_ack cycle, counted from the cycle req is raised
    int            exp_reqc;  // cycles down_reg_req is high
    logic [NT-1:0] exp_req;
    logic [NT-1:0] noise;     // acks driven on other targets every cycle
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int ack_dly, input logic [DW-1:0] tdata, input logic chk,
                              input logic [DW-1:0] exp_data, input int exp_lat, input int exp_reqc,
                              input logic [NT-1:0] exp_req, input logic [NT-1:0] noise);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.ack_dly = ack_dly; v.tdata = tdata;
    v.chk = chk; v.exp_data = exp_data; v.exp_lat = exp_lat; v.exp_reqc = exp_reqc;
    v.exp_req = exp_req; v.noise = noise;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string name, input vec_t v);
    int first_req = -1;
    int reqc = 0;
    int ackc = 0;
    int ack_cyc = -1;
    logic [5:0] tag = v.addr[AW-1:SW];
    up_reg_req     = 1'b1;
    up_reg_rd_wr_L = v.rd;
    up_reg_addr    = v.addr;
    up_reg_wr_data = v.wdata;
    for (int k = 0; k < NT; k++) begin
      down_reg_rd_data[k*DW +: DW] = (k == int'(tag)) ? v.tdata : (32'hBAD0_0000 | 32'(k));
    end
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      down_reg_ack = v.noise & ~v.exp_req;
      if (down_reg_req != 4'b0000) begin
        reqc++;
        if (first_req < 0) first_req = c;
        check({name, " down_req"}, 64'(down_reg_req), 64'(v.exp_req));
        check({name, " down_addr"}, 64'(down_reg_addr), 64'(v.addr[SW-1:0]));
        check({name, " down_wdata"}, 64'(down_reg_wr_data), 64'(v.wdata));
        check({name, " down_rd_wr_L"}, 64'(down_reg_rd_wr_L), 64'(v.rd));
        if (c - first_req == v.ack_dly) down_reg_ack = down_reg_ack | down_reg_req;
      end
      if (up_reg_ack) begin
        ackc++;
        ack_cyc = c;
        if (v.chk) check({name, " rd_data"}, 64'(up_reg_rd_data), 64'(v.exp_data));
        up_reg_req = 1'b0;
      end
    end
    down_reg_ack = 4'b0000;
    check({name, " ack_count"}, 64'(ackc), 64'd1);
    check({name, " ack_latency"}, 64'(ack_cyc), 64'(v.exp_lat));
    check({name, " down_req_cycles"}, 64'(reqc), 64'(v.exp_reqc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqc;
    int ackc;
    reset = 1'b1; up_reg_req = 1'b0; up_reg_rd_wr_L = 1'b0; up_reg_addr = '0;
    up_reg_wr_data = '0; down_reg_ack = '0; down_reg_rd_data = '0;

    vecs[0] = mk(1'b1, {6'd0, 16'h0004}, 32'h0000_0000, 1, 32'h0001_2345, 1'b1, 32'h0001_2345, 3, 2, 4'b0001, 4'b0000);
    vecs[1] = mk(1'b0, {6'd2, 16'h0010}, 32'hA5A5_A5A5, 0, 32'h0000_0000, 1'b0, 32'h0000_0000, 2, 1, 4'b0100, 4'b1011);
    vecs[2] = mk(1'b1, {6'd5, 16'h0020}, 32'h0000_0000, 99, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1, 0, 4'b0000, 4'b0000);
    vecs[3] = mk(1'b1, {6'd1, 16'h0030}, 32'h1111_1111, 99, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 9, 8, 4'b0010, 4'b0000);
    vecs[4] = mk(1'b1, {6'd1, 16'h0031}, 32'h0000_0000, 7, 32'h1234_5678, 1'b1, 32'h1234_5678, 9, 8, 4'b0010, 4'b0000);
    vecs[5] = mk(1'b0, {6'd3, 16'hFFFF}, 32'h5A5A_0F0F, 99, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 9, 8, 4'b1000, 4'b0111);
    vecs[6] = mk(1'b1, {6'd3, 16'h0100}, 32'h0000_0000, 2, 32'hCAFE_0003, 1'b1, 32'hCAFE_0003, 4, 3, 4'b1000, 4'b0000);
    vecs[7] = mk(1'b0, {6'd63, 16'h0001}, 32'h0000_0000, 99, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1, 0, 4'b0000, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    check("reset up_ack", 64'(up_reg_ack), 64'd0);
    check("reset rd_data", 64'(up_reg_rd_data), 64'd0);
    check("reset down_req", 64'(down_reg_req), 64'd0);
    check("reset down_addr", 64'(down_reg_addr), 64'd0);
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
    check("reset err_count", 64'(err_count), 64'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
    check("err_count after table", 64'(err_count), 64'd4);
    check("last_err_tag after table", 64'(last_err_tag), 64'd63);
`endif

    // Request held high long after its ack must not start a second transaction.
    up_reg_req = 1'b1; up_reg_rd_wr_L = 1'b1; up_reg_addr = {6'd0, 16'h0008}; up_reg_wr_data = '0;
    down_reg_rd_data = '0; down_reg_rd_data[31:0] = 32'h0000_00A1;
    reqc = 0; ackc = 0;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      down_reg_ack = down_reg_req;
      if (down_reg_req != 4'b0000) reqc++;
      if (up_reg_ack) begin
        ackc++;
        check("hold rd_data", 64'(up_reg_rd_data), 64'h0000_00A1);
      end
    end
    down_reg_ack = 4'b0000;
    check("hold ack_count", 64'(ackc), 64'd1);
    check("hold down_req_cycles", 64'(reqc), 64'd1);
    up_reg_req = 1'b0;
    @(posedge clk); #1;
    run_txn("rearm", mk(1'b1, {6'd0, 16'h0009}, 32'h0000_0000, 0, 32'h0000_00A2, 1'b1, 32'h0000_00A2, 2, 1, 4'b0001, 4'b0000));

    // Request abandoned mid-forward: downstream times out, no upstream ack, rd_data holds.
    up_reg_req = 1'b1; up_reg_rd_wr_L = 1'b1; up_reg_addr = {6'd1, 16'h0040};
    reqc = 0; ackc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 3) up_reg_req = 1'b0;
      if (down_reg_req != 4'b0000) reqc++;
      if (up_reg_ack) ackc++;
    end
    check("drop ack_count", 64'(ackc), 64'd0);
    check("drop down_req_cycles", 64'(reqc), 64'd8);
    check("drop rd_data hold", 64'(up_reg_rd_data), 64'h0000_00A2);
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
    check("drop err_count", 64'(err_count), 64'd4);
`endif
    run_txn("after_drop", mk(1'b1, {6'd2, 16'h0041}, 32'h0000_0000, 0, 32'h0000_0B0B, 1'b1, 32'h0000_0B0B, 2, 1, 4'b0100, 4'b0000));

    // Asynchronous reset in the middle of a forward.
    up_reg_req = 1'b1; up_reg_rd_wr_L = 1'b0; up_reg_addr = {6'd2, 16'h0050}; up_reg_wr_data = 32'h7777_7777;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
    end
    check("pre-reset down_req", 64'(down_reg_req), 64'b0100);
    #2;
    reset = 1'b1;
    #1;
    check("async reset down_req", 64'(down_reg_req), 64'd0);
    check("async reset up_ack", 64'(up_reg_ack), 64'd0);
    check("async reset rd_data", 64'(up_reg_rd_data), 64'd0);
    check("async reset down_addr", 64'(down_reg_addr), 64'd0);
    check("async reset down_wdata", 64'(down_reg_wr_data), 64'd0);
    check("async reset rd_wr_L", 64'(down_reg_rd_wr_L), 64'd0);
`ifdef CORE_REG_DISPATCH_ERR_CNT_EN
    check("async reset err_count", 64'(err_count), 64'd0);
    check("async reset last_err_tag", 64'(last_err_tag), 64'd0);
`endif
    up_reg_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_txn("post_reset", mk(1'b1, {6'd2, 16'h0051}, 32'h0000_0000, 1, 32'h0000_C0DE, 1'b1, 32'h0000_C0DE, 3, 2, 4'b0100, 4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_reg_dispatch.md
Name: core_reg_dispatch

Overview:
- Front-end controller for the core register bus.
- Accepts one upstream register request and decodes the tag bits above the sub-block address.
- Forwards the request to exactly one of NUM_TARGETS downstream register blocks (device ID block, MAC/queue register blocks, …) and returns that block's ack/data upstream.
- Unmapped tags and non-responding targets return 32'hDEAD_BEEF, so the host bus never hangs.

Parameters:
- ADDR_WIDTH, 22, upstream register word-address width.
- SUB_ADDR_WIDTH, 16, address width passed to each target; tag = up_reg_addr[ADDR_WIDTH-1:SUB_ADDR_WIDTH].
- NUM_TARGETS, 4, number of downstream register blocks (1..2^(ADDR_WIDTH-SUB_ADDR_WIDTH)).
- DATA_WIDTH, 32, register data width.
- TIMEOUT, 255, FWD-state cycles allowed before a timeout is declared (1..65535).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-high reset
- up_reg_req  in  1  upstream request (level), held until up_reg_ack
- up_reg_ack  out  1  one-cycle completion pulse
- up_reg_rd_wr_L  in  1  1=read, 0=write
- up_reg_addr  in  ADDR_WIDTH  word address
- up_reg_wr_data  in  DATA_WIDTH  write data
- up_reg_rd_data  out  DATA_WIDTH  read data, valid while up_reg_ack=1
- down_reg_req  out  NUM_TARGETS  one-hot per-target request (level)
- down_reg_rd_wr_L  out  1  latched rd_wr_L, shared by all targets
- down_reg_addr  out  SUB_ADDR_WIDTH  latched sub-address, shared
- down_reg_wr_data  out  DATA_WIDTH  latched write data, shared
- down_reg_ack  in  NUM_TARGETS  per-target ack
- down_reg_rd_data  in  NUM_TARGETS*DATA_WIDTH  per-target read data; target k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; up_reg_ack=0; up_reg_rd_data=0; down_reg_req=0; down_reg_addr/wr_data/rd_wr_L=0; timeout counter=0.
- States: IDLE, FWD, RESP, WAIT_DROP.
- IDLE: when up_reg_req=1, latch addr, wr_data, rd_wr_L and tag.
  - tag<NUM_TARGETS: next cycle down_reg_req[tag]=1, counter=0, go to FWD.
  - tag>=NUM_TARGETS: load rd_data=32'hDEAD_BEEF, go to RESP.
- FWD:
  - Counter increments each cycle.
  - If down_reg_ack[tag]=1: capture that target's rd_data slice, clear down_reg_req, go to RESP.
  - Else if counter==TIMEOUT-1: clear down_reg_req, load rd_data=32'hDEAD_BEEF, go to RESP.
  - Ack in the same cycle as the timeout condition: ack wins, real data returned.
  - Acks from non-selected targets are ignored.
- RESP: up_reg_ack=1 for exactly one cycle, then go to WAIT_DROP.
- WAIT_DROP: up_reg_ack=0; stay until up_reg_req=0, then go to IDLE. A new request needs req low for at least one cycle.
- Latency, mapped target: req sampled at cycle N → down_reg_req high at N+1. Target ack sampled at cycle M → up_reg_ack high at M+1, down_reg_req low at M+1.
- Latency, unmapped tag: req sampled at N → up_reg_ack at N+1.
- Writes follow the same flow. rd_data on a write ack is don't-care, but a timeout still returns DEAD_BEEF.
- Upstream req dropped during FWD (protocol violation):
  - The downstream transaction still completes (ack or timeout).
  - RESP is skipped, up_reg_ack is not asserted, and the block returns to IDLE.
- down_reg_req is never multi-hot. down_reg_addr/wr_data/rd_wr_L stay stable from the cycle down_reg_req rises until it falls.
- up_reg_rd_data holds its last value outside RESP.

Optional Feature:
- Macro: CORE_REG_DISPATCH_ERR_CNT_EN.
- Defined:
  - Adds output err_count (16 bits): a saturating counter, reset 0.
  - Increments by 1 on each RESP entered via timeout or unmapped tag; holds at 16'hFFFF.
  - Adds output last_err_tag (8 bits, reset 0): the tag of the most recent error.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Read tag 0: target 0 acks 1 cycle after down_reg_req with rd_data 32'h0001_2345 → up_reg_ack at N+3, up_reg_rd_data=32'h0001_2345, down_reg_req=4'b0001 for 2 cycles.
- Write tag 2, sub-addr 16'h0010, data 32'hA5A5_A5A5 → down_reg_req=4'b0100, down_reg_addr=16'h0010, down_reg_wr_data=A5A5A5A5, down_reg_rd_wr_L=0 while req high; exactly one up_reg_ack.
- Unmapped tag 5 (NUM_TARGETS=4) → no down_reg_req; up_reg_ack at N+1 with rd_data=32'hDEAD_BEEF; err_count=1 and last_err_tag=5 when macro defined.
- Target 1 never acks, TIMEOUT=8 → down_reg_req[1] high 8 cycles, then up_reg_ack with DEAD_BEEF. With the target acking in exactly the 8th FWD cycle → real data returned.
- up_reg_req held high for 10 cycles after ack → one ack only, no second down_reg_req. Req low 1 cycle then high → new transaction starts.
- Assert reset during FWD → all outputs 0 immediately (asynchronously). After release, with up_reg_req low → IDLE, and a subsequent read completes normally.
